// File: rtl/tape_punch_buffer_pkg.sv
// tape_pkg: shared widths, FSM encoding and byte padding for the tape punch buffer
package tape_pkg;
  localparam int CODE_W = 5;
  localparam int HOST_W = 8;
  localparam logic [HOST_W-CODE_W-1:0] BYTE_PAD = 3'b000;
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_e;
  function automatic logic [HOST_W-1:0] pad_code(input logic [CODE_W-1:0] code);
    return {BYTE_PAD, code};
  endfunction
endpackage

// File: rtl/tape_punch_buffer_if.sv
// tape_punch_buffer_if: core-side 4-phase output port plus host-side valid/ready byte stream
interface tape_punch_buffer_if;
  import tape_pkg::*;
  logic              dev_output_rdy;
  logic [CODE_W-1:0] dev_output_data;
  logic              dev_output_ack;
  logic              host_valid;
  logic              host_ready;
  logic [HOST_W-1:0] host_data;
  modport master (
    output dev_output_rdy, dev_output_data, host_ready,
    input  dev_output_ack, host_valid, host_data
  );
  modport slave (
    input  dev_output_rdy, dev_output_data, host_ready,
    output dev_output_ack, host_valid, host_data
  );
endinterface

// File: rtl/tape_punch_buffer_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO, output read from the head slot, no fall-through
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      lvl_q;
  logic             do_push, do_pop;
  assign empty_o = lvl_q == '0;
  assign full_o  = lvl_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  // a pop in the same cycle frees the slot a push into a full FIFO lands in
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];
  assign level_o = lvl_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/tape_punch_buffer.sv
// tape_punch_buffer: paced 4-phase capture of core output codes into a FIFO feeding a host byte stream
module tape_punch_buffer
  import tape_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int PUNCH_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  tape_punch_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       punch_count,
  output logic                   pnl_punch_busy
);
  localparam int PW = PUNCH_CYCLES > 1 ? $clog2(PUNCH_CYCLES) : 1;
  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [PW-1:0]     pace_q, pace_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              capture, full, empty;
  logic [CODE_W-1:0] dout;
  always_comb begin
    capture = state_q == IDLE && bus.dev_output_rdy && !full && pace_q == '0;
    state_d = capture ? WAIT_LOW
            : (state_q == WAIT_LOW && !bus.dev_output_rdy) ? IDLE : state_q;
    ack_d   = capture;
    cnt_d   = cnt_q + CNT_W'(capture);
    pace_d  = capture ? PW'(PUNCH_CYCLES - 1) : pace_q - PW'(pace_q != '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      pace_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      pace_q  <= pace_d;
      cnt_q   <= cnt_d;
    end
  end
  sync_fifo #(.WIDTH(CODE_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (capture),
    .din_i   (bus.dev_output_data),
    .pop_i   (bus.host_ready),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  assign bus.dev_output_ack = ack_q;
  assign bus.host_valid     = !empty;
  assign bus.host_data      = pad_code(dout);
  assign punch_count        = cnt_q;
  assign pnl_punch_busy     = state_q != IDLE;
endmodule

// File: tb/tb_tape_punch_buffer.sv
// tb_tape_punch_buffer: directed checks of capture, pacing, backpressure, FIFO order and reset
module tb_tape_punch_buffer;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] fifo_level;
  logic [3:0] punch_count;
  logic       busy;
  int         tests = 0, fails = 0, cycle = 0;
  tape_punch_buffer_if bus();
  tape_punch_buffer #(.DEPTH(16), .PUNCH_CYCLES(8), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .fifo_level     (fifo_level),
    .punch_count    (punch_count),
    .pnl_punch_busy (busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic wait_ack(input string tag, input int lim);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (bus.dev_output_ack !== 1'b1 && n < lim);
    chk(tag, bus.dev_output_ack, 1);
  endtask
  task automatic punch(input logic [4:0] code, input string tag);
    bus.dev_output_data = code;
    bus.dev_output_rdy  = 1'b1;
    wait_ack(tag, 30);
    bus.dev_output_rdy  = 1'b0;
    cyc();
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask
  initial begin
    int acks, peak, t0;
    logic [4:0] drain [15];
    reset = 1'b1;
    bus.dev_output_rdy = 1'b0;
    bus.dev_output_data = '0;
    bus.host_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_ack", bus.dev_output_ack, 0);
    chk("rst_valid", bus.host_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_count", punch_count, 0);
    chk("rst_busy", busy, 0);
    // single code
    bus.dev_output_data = 5'o27;
    bus.dev_output_rdy = 1'b1;
    bus.host_ready = 1'b1;
    cyc();
    chk("t1_ack", bus.dev_output_ack, 1);
    chk("t1_valid", bus.host_valid, 1);
    chk("t1_data", bus.host_data, 8'h17);
    chk("t1_count", punch_count, 1);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_ack_low", bus.dev_output_ack, 0);
    chk("t1_popped", bus.host_valid, 0);
    chk("t1_busy_hold", busy, 1);
    bus.dev_output_rdy = 1'b0;
    cyc();
    chk("t1_idle", busy, 0);
    // held rdy
    bus.host_ready = 1'b0;
    pulse_reset();
    bus.dev_output_data = 5'h0A;
    bus.dev_output_rdy = 1'b1;
    acks = 0;
    peak = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (bus.dev_output_ack) acks++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    chk("t2_one_ack", acks, 1);
    chk("t2_peak", peak, 1);
    chk("t2_count", punch_count, 1);
    bus.dev_output_rdy = 1'b0;
    cyc();
    bus.dev_output_data = 5'h0B;
    bus.dev_output_rdy = 1'b1;
    wait_ack("t2_second_ack", 20);
    bus.dev_output_rdy = 1'b0;
    chk("t2_count2", punch_count, 2);
    chk("t2_level2", fifo_level, 2);
    bus.host_ready = 1'b1;
    chk("t2_head0", bus.host_data, 8'h0A);
    cyc();
    chk("t2_head1", bus.host_data, 8'h0B);
    cyc();
    chk("t2_drained", bus.host_valid, 0);
    // pacing
    pulse_reset();
    t0 = 0;
    for (int c = 1; c <= 4; c++) begin
      bus.dev_output_data = 5'(c);
      bus.dev_output_rdy = 1'b1;
      wait_ack($sformatf("t3_ack%0d", c), 30);
      chk($sformatf("t3_data%0d", c), bus.host_data, 8'(c));
      if (c > 1) chk($sformatf("t3_gap%0d", c), cycle - t0, 8);
      t0 = cycle;
      bus.dev_output_rdy = 1'b0;
      cyc();
    end
    // full backpressure
    bus.host_ready = 1'b0;
    pulse_reset();
    for (int c = 0; c < 16; c++) punch(5'(c), $sformatf("t4_fill%0d", c));
    chk("t4_level_full", fifo_level, 16);
    chk("t4_count_wrap", punch_count, 0);
    bus.dev_output_data = 5'h1F;
    bus.dev_output_rdy = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.dev_output_ack) acks++;
    end
    chk("t4_no_ack", acks, 0);
    chk("t4_head", bus.host_data, 8'h00);
    bus.host_ready = 1'b1;
    cyc();
    bus.host_ready = 1'b0;
    chk("t4_level_15", fifo_level, 15);
    wait_ack("t4_late_ack", 8);
    chk("t4_refull", fifo_level, 16);
    chk("t4_count17", punch_count, 1);
    bus.dev_output_rdy = 1'b0;
    cyc();
    // simultaneous push/pop near full, then at empty
    bus.host_ready = 1'b1;
    cyc();
    bus.host_ready = 1'b0;
    repeat (10) cyc();
    chk("t5_head2", bus.host_data, 8'h02);
    bus.dev_output_data = 5'h15;
    bus.dev_output_rdy = 1'b1;
    bus.host_ready = 1'b1;
    cyc();
    chk("t5_ack", bus.dev_output_ack, 1);
    chk("t5_level_same", fifo_level, 15);
    bus.dev_output_rdy = 1'b0;
    for (int i = 0; i < 13; i++) drain[i] = 5'(i + 3);
    drain[13] = 5'h1F;
    drain[14] = 5'h15;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t5_order%0d", i), bus.host_data, {3'b000, drain[i]});
      cyc();
    end
    chk("t5_empty", bus.host_valid, 0);
    chk("t5_level0", fifo_level, 0);
    repeat (10) cyc();
    bus.dev_output_data = 5'h09;
    bus.dev_output_rdy = 1'b1;
    cyc();
    chk("t5_e_ack", bus.dev_output_ack, 1);
    chk("t5_e_valid", bus.host_valid, 1);
    chk("t5_e_data", bus.host_data, 8'h09);
    bus.dev_output_rdy = 1'b0;
    cyc();
    chk("t5_e_popped", bus.host_valid, 0);
    chk("t5_count", punch_count, 3);
    // reset mid-operation, then counter wrap
    bus.host_ready = 1'b0;
    pulse_reset();
    for (int c = 0; c < 4; c++) punch(5'(c + 20), $sformatf("t6_fill%0d", c));
    bus.dev_output_data = 5'h07;
    bus.dev_output_rdy = 1'b1;
    wait_ack("t6_ack5", 30);
    chk("t6_busy", busy, 1);
    chk("t6_level5", fifo_level, 5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.dev_output_rdy = 1'b0;
    chk("t6_ack", bus.dev_output_ack, 0);
    chk("t6_valid", bus.host_valid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_count", punch_count, 0);
    chk("t6_idle", busy, 0);
    bus.host_ready = 1'b1;
    for (int c = 0; c < 17; c++) punch(5'(c), $sformatf("t6_wrap%0d", c));
    chk("t6_wrap_count", punch_count, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tape_punch_buffer.md
Name: tape_punch_buffer

Overview:
Output-device emulator sitting directly downstream of the core's output port (dev_output_rdy / dev_output_data / dev_output_ack). It accepts 5-bit codes from the core using a 4-phase handshake. It spaces successive accepts by a programmable punch interval and buffers the codes in a FIFO. It presents the codes as zero-extended bytes on a valid/ready stream toward the host link (UART or trace logger). A full FIFO holds back ack, so the core stalls naturally.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256.
PUNCH_CYCLES, 8, minimum clk cycles from one ack pulse to the next; >=1.
CNT_W, 16, width of the punched-code counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dev_output_rdy  in  1  core has a code on dev_output_data (level)
dev_output_data  in  5  code from core; valid while dev_output_rdy=1
dev_output_ack  out  1  one-cycle accept pulse to core
host_valid  out  1  byte available
host_ready  in  1  host accepts byte
host_data  out  8  {3'b000, code}
fifo_level  out  $clog2(DEPTH)+1  current occupancy
punch_count  out  CNT_W  codes accepted since reset; wraps modulo 2^CNT_W
pnl_punch_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: FSM=IDLE, dev_output_ack=0, host_valid=0, fifo_level=0, punch_count=0, pace counter=0, FIFO pointers=0. Reset mid-handshake drops ack and discards buffered data. The core must then see rdy dropped or re-presented; no partial code is kept.
- FSM states and transitions:
  - IDLE: if dev_output_rdy=1 and FIFO not full and pace counter=0, write dev_output_data into the FIFO, assert dev_output_ack for exactly this one cycle (registered, so ack is visible on the next cycle), increment punch_count, load pace counter with PUNCH_CYCLES-1, and go to WAIT_LOW.
  - IDLE: if the FIFO is full, stay in IDLE with ack=0 (backpressure).
  - WAIT_LOW: ack=0; wait for dev_output_rdy=0, then go to IDLE. A rdy held high never causes a second capture.
  - The pace counter decrements every cycle while nonzero, independent of state. A new accept is legal only when it reads 0, so successive ack pulses are >= PUNCH_CYCLES cycles apart. With PUNCH_CYCLES=1 there is no extra spacing.
- Latency: rdy rising with conditions met -> ack high 1 cycle later. Data written at capture -> host_valid high 1 cycle later if the FIFO was empty (no fall-through).
- FIFO: synchronous, registered output. host_valid = FIFO not empty. A pop occurs on host_valid & host_ready.
  - Simultaneous push and pop in the same cycle: level unchanged; legal when full (pop frees the slot and the push lands in it) and when empty (no bypass; the pushed byte appears next cycle).
  - Pointers wrap modulo DEPTH. fifo_level saturates at DEPTH by construction; no overflow or underflow is ever possible.
- host_data is stable while host_valid=1 and host_ready=0.
- punch_count rolls over from all-ones to 0 with no flag.

Decomposition:
- Shared package tape_pkg:
  - CODE_W=5.
  - FSM state encoding: IDLE=1'b0, WAIT_LOW=1'b1.
  - Byte-pad constant 3'b000.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), reusable for the input-side tape reader.
- FSM, pace counter and punch counter live in tape_punch_buffer.

Test Plan:
1. Single code: reset, rdy=1 with data=5'o27, host_ready=1 -> ack pulses 1 cycle once; host_data=8'h17 for 1 cycle; punch_count=1; pnl_punch_busy high until rdy drops.
2. Held rdy: rdy held high for 50 cycles -> exactly one ack, fifo_level peaks at 1, punch_count=1. Drop rdy, raise it again -> second ack.
3. Pacing: PUNCH_CYCLES=8, core re-presents rdy immediately after each ack for codes 1..4 -> ack rising edges exactly 8 cycles apart; host receives 8'h01..8'h04 in order.
4. Full backpressure: host_ready=0, push 16 codes (DEPTH=16) -> fifo_level=16. The 17th rdy gets no ack until host_ready=1 for one cycle; then ack follows within PUNCH_CYCLES and fifo_level returns to 16.
5. Simultaneous push/pop at full and at empty -> level unchanged (full) or host_valid delayed by 1 cycle (empty); data order preserved.
6. Reset mid-operation: 5 bytes buffered, FSM in WAIT_LOW, assert reset 1 cycle -> next cycle host_valid=0, fifo_level=0, punch_count=0, ack=0. Counter wrap (CNT_W=4): 17 accepts -> punch_count=1.
